// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase-generation path.
package dds_pkg;

    // Default accumulator / step width.
    localparam int DDS_ACC_W       = 32;
    // Number of entries in the coarse step table.
    localparam int DDS_TABLE_DEPTH = 16;

    // Coarse step table exchanged with the Avalon-MM register interface.
    typedef logic [DDS_ACC_W-1:0] step_table_t [DDS_TABLE_DEPTH];

    // Phase generator control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } dds_state_e;

endpackage

// File: rtl/dds_fine_offset_counter.sv
// Signed saturating fine-offset counter. It is cleared whenever the step
// selector or the adjust mode changes, and held at zero in coarse-only mode.
module dds_fine_offset_counter
    import dds_pkg::*;
#(
    parameter int FINE_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_tipo_ajuste,
    input  logic [3:0]               i_step_sel,
    input  logic                     i_fine_up,
    input  logic                     i_fine_down,
    output logic signed [FINE_W-1:0] o_fine
);

    localparam logic signed [FINE_W-1:0] FINE_MAX = {1'b0, {(FINE_W-1){1'b1}}};
    localparam logic signed [FINE_W-1:0] FINE_MIN = {1'b1, {(FINE_W-1){1'b0}}};
    localparam logic signed [FINE_W-1:0] FINE_ONE = 1;

    logic signed [FINE_W-1:0] r_fine;
    logic [3:0]               r_step_sel_q;
    logic                     r_tipo_q;

    logic w_change;
    logic w_up;
    logic w_down;

    // A selector or mode change wins over any pulse arriving in the same cycle.
    assign w_change = (i_step_sel != r_step_sel_q) || (i_tipo_ajuste != r_tipo_q);
    // Opposing pulses in the same cycle cancel out.
    assign w_up     = i_fine_up & ~i_fine_down;
    assign w_down   = i_fine_down & ~i_fine_up;

    // Track selector/mode history and update the saturating offset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fine       <= '0;
            r_step_sel_q <= '0;
            r_tipo_q     <= 1'b0;
        end else begin
            r_step_sel_q <= i_step_sel;
            r_tipo_q     <= i_tipo_ajuste;
            if (!i_tipo_ajuste || w_change) begin
                r_fine <= '0;
            end else if (w_up && (r_fine != FINE_MAX)) begin
                r_fine <= r_fine + FINE_ONE;
            end else if (w_down && (r_fine != FINE_MIN)) begin
                r_fine <= r_fine - FINE_ONE;
            end
        end
    end

    assign o_fine = r_fine;

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase generator: forms a clamped effective step from the coarse table
// and the fine offset, and advances a phase accumulator on each sample tick.
module dds_phase_accumulator
    import dds_pkg::*;
#(
    parameter int ACC_W   = DDS_ACC_W,
    parameter int PHASE_W = 12,
    parameter int FINE_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ACC_W-1:0]   i_coarse_step_rom [DDS_TABLE_DEPTH],
    input  logic               i_enable,
    input  logic               i_tipo_ajuste,
    input  logic [3:0]         i_step_sel,
    input  logic               i_fine_up,
    input  logic               i_fine_down,
    input  logic               i_sample_tick,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_valid,
    output logic               o_wrap,
    output logic [ACC_W-1:0]   o_step,
    output logic               o_running
);

    dds_state_e         r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_step;
    logic [ACC_W-1:0]   r_coarse;
    logic               r_valid;
    logic               r_wrap;
    logic               r_running;

    logic signed [FINE_W-1:0] w_fine;
    logic [ACC_W+1:0]         w_fine_ext;
    logic [ACC_W+1:0]         w_sum;
    logic [ACC_W-1:0]         w_step_clamped;
    logic [ACC_W:0]           w_acc_next;

    dds_fine_offset_counter #(
        .FINE_W (FINE_W)
    ) u_fine_offset (
        .clock         (clock),
        .reset         (reset),
        .i_tipo_ajuste (i_tipo_ajuste),
        .i_step_sel    (i_step_sel),
        .i_fine_up     (i_fine_up),
        .i_fine_down   (i_fine_down),
        .o_fine        (w_fine)
    );

    // Register the selected coarse entry so table and selector changes line
    // up with the fine-offset clear one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_coarse <= '0;
        end else begin
            r_coarse <= i_coarse_step_rom[i_step_sel];
        end
    end

    // Coarse + signed fine at ACC_W+2 bits, clamped to the unsigned step range.
    // NOTE: every combinational output gets a value on every path so no latch
    // is inferred.
    always_comb begin
        w_fine_ext = {{(ACC_W+2-FINE_W){w_fine[FINE_W-1]}}, w_fine};
        w_sum      = {2'b00, r_coarse} + w_fine_ext;
        if (w_sum[ACC_W+1]) begin
            w_step_clamped = '0;
        end else if (w_sum[ACC_W]) begin
            w_step_clamped = '1;
        end else begin
            w_step_clamped = w_sum[ACC_W-1:0];
        end
    end

    // Carry-out of the accumulator add becomes the wrap flag.
    assign w_acc_next = {1'b0, r_acc} + {1'b0, r_step};

    // Control FSM with registered accumulator, step and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_step    <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_acc     <= '0;
                    r_step    <= '0;
                    r_running <= 1'b0;
                    if (i_enable) begin
                        r_state <= START;
                    end
                end
                START: begin
                    r_acc     <= '0;
                    r_step    <= w_step_clamped;
                    r_running <= 1'b1;
                    r_state   <= RUN;
                end
                RUN: begin
                    if (!i_enable) begin
                        r_state   <= IDLE;
                        r_acc     <= '0;
                        r_step    <= '0;
                        r_running <= 1'b0;
                    end else begin
                        // The tick uses the step already in r_step; the new
                        // step only applies to later ticks.
                        r_step <= w_step_clamped;
                        if (i_sample_tick) begin
                            {r_wrap, r_acc} <= w_acc_next;
                            r_valid         <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_phase   = r_acc[ACC_W-1 -: PHASE_W];
    assign o_valid   = r_valid;
    assign o_wrap    = r_wrap;
    assign o_step    = r_step;
    assign o_running = r_running;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Self-checking bench for dds_phase_accumulator: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_dds_phase_accumulator;
    import dds_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    step_table_t rom;
    logic        enable = 1'b0;
    logic        tipo = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic        tick = 1'b0;

    logic [11:0] o_phase;
    logic        o_valid;
    logic        o_wrap;
    logic [31:0] o_step;
    logic        o_running;

    int n_checks = 0;
    int n_errors = 0;

    dds_phase_accumulator dut (
        .clock             (clock),
        .reset             (reset),
        .i_coarse_step_rom (rom),
        .i_enable          (enable),
        .i_tipo_ajuste     (tipo),
        .i_step_sel        (sel),
        .i_fine_up         (up),
        .i_fine_down       (down),
        .i_sample_tick     (tick),
        .o_phase           (o_phase),
        .o_valid           (o_valid),
        .o_wrap            (o_wrap),
        .o_step            (o_step),
        .o_running         (o_running)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = idle, 1 = starting, 2 = running
    int      m_mode;
    int      m_fine;
    int      m_sel_prev;
    bit      m_tipo_prev;
    longint  m_coarse_seen;   // table entry as selected one edge ago
    longint  m_step;
    longint  m_acc;
    bit      m_valid;
    bit      m_wrap;

    function automatic longint clamp_step(input longint coarse, input int fine);
        longint s;
        s = coarse + longint'(fine);
        if (s < 0) return 0;
        if (s > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
        return s;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_fine = 0; m_sel_prev = 0; m_tipo_prev = 0;
            m_coarse_seen = 0; m_step = 0; m_acc = 0; m_valid = 0; m_wrap = 0;
        end else begin
            longint new_step;
            longint sum;
            new_step = clamp_step(m_coarse_seen, m_fine);
            m_valid = 0;
            m_wrap  = 0;
            if (m_mode == 0) begin
                m_acc = 0; m_step = 0;
                if (enable) m_mode = 1;
            end else if (m_mode == 1) begin
                m_acc = 0; m_step = new_step; m_mode = 2;
            end else if (!enable) begin
                m_mode = 0; m_acc = 0; m_step = 0;
            end else begin
                if (tick) begin
                    sum = m_acc + m_step;
                    m_wrap = (sum >= 64'h1_0000_0000);
                    m_acc = sum % 64'h1_0000_0000;
                    m_valid = 1;
                end
                m_step = new_step;
            end
            // fine offset bookkeeping
            if (!tipo || int'(sel) != m_sel_prev || tipo != m_tipo_prev) m_fine = 0;
            else if (up && !down) m_fine = (m_fine < 32767) ? m_fine + 1 : 32767;
            else if (down && !up) m_fine = (m_fine > -32768) ? m_fine - 1 : -32768;
            m_sel_prev    = int'(sel);
            m_tipo_prev   = tipo;
            m_coarse_seen = longint'(rom[sel]);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        check("phase",   64'(o_phase),   64'(m_acc >> 20));
        check("valid",   64'(o_valid),   64'(m_valid));
        check("wrap",    64'(o_wrap),    64'(m_wrap));
        check("step",    64'(o_step),    64'(m_step));
        check("running", 64'(o_running), 64'(m_mode == 2));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_up();
        up = 1'b1; cyc(1); up = 1'b0; cyc(1);
    endtask

    initial begin
        int n;
        bit got;
        for (int i = 0; i < 16; i++) rom[i] = 32'd0;
        #1 reset = 1'b1;
        cyc(2);
        check("reset_phase",   64'(o_phase),   64'd0);
        check("reset_valid",   64'(o_valid),   64'd0);
        check("reset_step",    64'(o_step),    64'd0);
        check("reset_running", 64'(o_running), 64'd0);
        #2 reset = 1'b0;
        cyc(3);
        check("idle_hold_running", 64'(o_running), 64'd0);

        // ---- wrap: 16 updates of 0x100, carry on the last only ----
        rom[3] = 32'h1000_0000; sel = 4'd3; tipo = 1'b0;
        cyc(2);
        enable = 1'b1; tick = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 16; c++) begin
            cyc(1);
            if (o_valid) begin
                n++;
                check("wrap_seq_phase", 64'(o_phase), 64'((n * 256) & 12'hFFF));
                check("wrap_seq_flag",  64'(o_wrap),  64'(n == 16));
            end
        end
        check("wrap_update_count", 64'(n), 64'd16);

        // ---- disable coincident with a tick ----
        cyc(3);
        enable = 1'b0;
        cyc(1);
        check("disable_valid",   64'(o_valid),   64'd0);
        check("disable_phase",   64'(o_phase),   64'd0);
        check("disable_running", 64'(o_running), 64'd0);
        enable = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            cyc(1);
            if (o_valid) begin
                got = 1;
                check("restart_first_phase", 64'(o_phase), 64'h100);
            end
        end
        check("restart_seen", 64'(got), 64'd1);
        tick = 1'b0;

        // ---- fine adjust ----
        rom[0] = 32'd100; rom[1] = 32'd200; sel = 4'd0; tipo = 1'b1;
        cyc(3);
        repeat (3) pulse_up();
        cyc(2);
        check("fine_step_103", 64'(o_step), 64'd103);
        sel = 4'd1;
        cyc(1);
        check("sel_change_old_step", 64'(o_step), 64'd103);
        cyc(1);
        check("sel_change_step_200", 64'(o_step), 64'd200);

        // ---- clamps ----
        rom[2] = 32'd0; sel = 4'd2;
        cyc(2);
        down = 1'b1; cyc(5); down = 1'b0;
        cyc(2);
        check("clamp_low", 64'(o_step), 64'd0);
        rom[4] = 32'hFFFF_FFFF; sel = 4'd4;
        cyc(2);
        pulse_up();
        cyc(2);
        check("clamp_high", 64'(o_step), 64'hFFFF_FFFF);

        // ---- fine saturation ----
        sel = 4'd2;
        cyc(2);
        up = 1'b1; cyc(40000); up = 1'b0;
        cyc(2);
        check("fine_saturate", 64'(o_step), 64'd32767);
        down = 1'b1; cyc(1); down = 1'b0;
        cyc(2);
        check("fine_after_sat_down", 64'(o_step), 64'd32766);

        // ---- simultaneous events ----
        up = 1'b1; down = 1'b1; cyc(1); up = 1'b0; down = 1'b0;
        cyc(2);
        check("up_down_cancel", 64'(o_step), 64'd32766);
        sel = 4'd1; up = 1'b1; cyc(1); up = 1'b0;
        cyc(2);
        check("pulse_with_sel_change", 64'(o_step), 64'd200);

        // ---- randomized traffic ----
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 3)  enable = ~enable;
            if ($urandom_range(99) < 2)  tipo = ~tipo;
            if ($urandom_range(99) < 4)  sel = 4'($urandom_range(15));
            if ($urandom_range(99) < 3) begin
                case ($urandom_range(2))
                    0:       rom[$urandom_range(15)] = $urandom;
                    1:       rom[$urandom_range(15)] = 32'($urandom_range(50));
                    default: rom[$urandom_range(15)] = 32'hFFFF_FFFF - 32'($urandom_range(50));
                endcase
            end
            tick = ($urandom_range(1) == 1);
            up   = ($urandom_range(99) < 15);
            down = ($urandom_range(99) < 15);
            cyc(1);
        end
        up = 1'b0; down = 1'b0; tick = 1'b0;

        // ---- reset mid-run with a non-zero accumulator ----
        rom[5] = 32'h1234_5678; sel = 4'd5; tipo = 1'b0; enable = 1'b1;
        cyc(4);
        tick = 1'b1; cyc(2); tick = 1'b0;
        check("pre_reset_phase", 64'(o_phase), 64'h246);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_phase",   64'(o_phase),   64'd0);
        check("midrun_reset_valid",   64'(o_valid),   64'd0);
        check("midrun_reset_wrap",    64'(o_wrap),    64'd0);
        check("midrun_reset_step",    64'(o_step),    64'd0);
        check("midrun_reset_running", 64'(o_running), 64'd0);
        cyc(1);
        #2 reset = 1'b0;
        enable = 1'b0;
        cyc(4);
        check("post_reset_idle", 64'(o_running), 64'd0);
        enable = 1'b1;
        cyc(3);
        check("post_reset_run", 64'(o_running), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_phase_accumulator.md
# dds_phase_accumulator

Phase-generation stage of the DDS. It consumes the coarse-step table, `enable` and `tipo_ajuste` registers exported by the Avalon-MM register interface, plus a step selector and fine-adjust pulses from the front panel. It forms an effective phase step, applies it to an N-bit accumulator on every sample tick, and delivers truncated phase words with a valid strobe to the downstream waveform LUT.

## Interface
- `ACC_W`, 32: accumulator and step width.
- `PHASE_W`, 12: width of the phase word sent to the LUT. Must be ≤ `ACC_W`.
- `FINE_W`, 16: width of the signed fine-offset counter.

Ports (reset: reset, asynchronous, active-high; clock: clock):
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_coarse_step_rom`  in  `ACC_W` ×16  coarse step table from the register interface.
- `i_enable`  in  1  run request.
- `i_tipo_ajuste`  in  1  0 = coarse only, 1 = coarse + fine offset.
- `i_step_sel`  in  4  table index.
- `i_fine_up`  in  1  single-cycle pulse: fine offset +1.
- `i_fine_down`  in  1  single-cycle pulse: fine offset −1.
- `i_sample_tick`  in  1  single-cycle sample-rate strobe.
- `o_phase`  out  `PHASE_W`  equals `acc[ACC_W-1 -: PHASE_W]`.
- `o_valid`  out  1  `o_phase` updated this cycle.
- `o_wrap`  out  1  accumulator carried out on this update.
- `o_step`  out  `ACC_W`  registered effective step (status/debug).
- `o_running`  out  1  state == RUN.

## Operation
- **FSM states:** IDLE, START, RUN.
  - IDLE: when `i_enable`=1, go to START.
  - START: always go to RUN after one cycle. Clears `acc` to 0 and loads `step_reg`.
  - RUN: when `i_enable`=0, go to IDLE. The accumulator is cleared on that same edge.
- **Fine offset:** signed `FINE_W`-bit counter.
  - Held at 0 while `i_tipo_ajuste`=0.
  - `i_fine_up` alone increments; `i_fine_down` alone decrements; both together cause no change.
  - Saturates at −2^(FINE_W−1) and 2^(FINE_W−1)−1.
  - Clears to 0 on a change of `i_step_sel` or `i_tipo_ajuste`, detected against a registered copy of each. The clear has priority over a simultaneous pulse.
  - Pulses are accepted in all FSM states.
- **Effective step:** `coarse[i_step_sel]` zero-extended plus `sext(fine)`, computed at `ACC_W`+2 bits signed and clamped to [0, 2^ACC_W−1]. The result is registered into `step_reg` every cycle in START and RUN; in IDLE it is held at 0.
- **Accumulate:** in RUN, when `i_sample_tick`=1, `acc <= acc + step_reg`, modulo 2^ACC_W. The carry-out drives `o_wrap`.
  - Ticks in IDLE and START are ignored.
  - With step 0, `acc` is unchanged but `o_valid` still pulses.
- The accumulator is phase-continuous across step changes; it is cleared only by START, by leaving RUN, or by reset.

## Timing
- **Reset values:** `acc`=0, `step_reg`=0, fine=0, state=IDLE. Outputs: `o_phase`=0, `o_valid`=0, `o_wrap`=0, `o_step`=0, `o_running`=0.
- **Enable:** `i_enable` sampled 1 at edge k gives START after edge k and RUN after edge k+1. The first tick that can be accepted is the one sampled at edge k+2.
- **Tick latency:** tick sampled at edge t gives `o_phase` updated, `o_valid`=1 and `o_wrap` (when there was a carry) after edge t, for exactly one cycle. Back-to-back ticks each produce an update.
- **Step latency:**
  - A change in table, `i_step_sel` or fine offset at edge t appears in `step_reg` after edge t+1. A tick sampled at edge t+1 still uses the old step.
  - A fine pulse at edge t updates the offset after t, `step_reg` after t+1, and applies to ticks sampled from t+2 onward.
- **Disable:** `i_enable`=0 sampled at edge t in RUN gives `acc`=0, `o_phase`=0 and `o_running`=0 after edge t. A tick at edge t is discarded, so `o_valid`=0.
- **Reset mid-run:** takes effect asynchronously. All state returns to the reset values immediately.

## Structure
- Package `dds_pkg`: `ACC_W` default constant, `step_table_t` (array of 16 × `ACC_W`), and the FSM enum `dds_state_e` {IDLE, START, RUN}. The register interface shares `step_table_t`.
- Sub-module `dds_fine_offset_counter`: saturating up/down counter with a synchronous clear and change detection on selector/mode. It is instantiated once.

## Test plan
- **Reset:** assert `reset` mid-run with `acc`≠0 → every output reads 0 within the same cycle. After release, the block stays in IDLE until `i_enable`=1.
- **Wrap:** coarse[3]=0x1000_0000, sel=3, `tipo_ajuste`=0, enable, tick every cycle → `o_phase` = 0x100, 0x200, …, 0xF00, then 0x000 with `o_wrap`=1 on the 16th update only.
- **Fine adjust:** coarse[0]=100, `tipo_ajuste`=1, three `i_fine_up` pulses → `o_step`=103. Then change sel to 1 (coarse 200) → fine cleared, `o_step`=200 two cycles later.
- **Clamp:**
  - coarse=0 with five `i_fine_down` pulses → `o_step`=0.
  - coarse=0xFFFF_FFFF with one `i_fine_up` pulse → `o_step`=0xFFFF_FFFF.
  - 40000 up pulses → fine saturates at 32767.
- **Simultaneous events:** `i_fine_up` and `i_fine_down` in the same cycle → offset unchanged. A pulse coincident with a sel change → offset is 0.
- **Disable mid-run:** `i_enable` deasserted at the same edge as a tick → `o_valid`=0, `o_phase`=0 and `o_running`=0 after that edge. Re-enabling restarts from phase 0.
